// File: rtl/hub75_pkg.sv
// hub75_pkg: shared state encoding and width helpers for the HUB75 BCM scheduler.
package hub75_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_GO, S_SWAIT, S_DWAIT, S_BLANK, S_LATCH, S_SHOW
    } state_t;

    function automatic int tmr_width(input int n_planes);
        return 8 + n_planes - 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: loadable down-counter; done while the count is zero.
module hub75_bcm_timer #(
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);

    always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;

    assign done_o = cnt_q == '0;
endmodule

// File: rtl/hub75_bcm_sched.sv
// hub75_bcm_sched: BCM scan scheduler; overlaps each plane shift with the display of the
// previously latched plane and drives the HUB75 row address, latch and blanking lines.
module hub75_bcm_sched
    import hub75_pkg::*;
#(
    parameter int N_ROWS     = 32,
    parameter int N_PLANES   = 8,
    parameter int T_BLANK    = 2,
    parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_run,
    input  logic [7:0]            cfg_lsb_len,
    output logic                  frame_start,
    output logic [LOG_N_ROWS-1:0] shift_row,
    output logic [N_PLANES-1:0]   shift_plane,
    output logic                  shift_go,
    input  logic                  shift_rdy,
    output logic [LOG_N_ROWS-1:0] phy_addr,
    output logic                  phy_le,
    output logic                  phy_blank
);
    localparam int TW = tmr_width(N_PLANES);
    localparam int PW = idx_width(N_PLANES);
    localparam int BW = idx_width(T_BLANK);

    state_t                state_q, state_d;
    logic [LOG_N_ROWS-1:0] nrow_q, nrow_d, srow_q, srow_d, addr_q, addr_d;
    logic [PW-1:0]         npl_q, npl_d, spl_q, spl_d;
    logic [N_PLANES-1:0]   oh_q, oh_d;
    logic [BW-1:0]         blk_q, blk_d;
    logic                  go_q, go_d, fs_q, fs_d, le_q, le_d, blank_q, blank_d;
    logic                  stop_q, stop_d, skip_q;
    logic                  last, pl_last, tmr_done;
    logic [TW-1:0]         lit, tmr_val;

    // The SHOW cycle and the DWAIT exit cycle are part of the lit window, hence the -2.
    always_comb begin
        pl_last = npl_q == PW'(N_PLANES - 1);
        last    = pl_last && nrow_q == LOG_N_ROWS'(N_ROWS - 1);
        lit     = TW'(cfg_lsb_len) << spl_q;
        tmr_val = lit > TW'(2) ? lit - TW'(2) : '0;
        state_d = state_q;
        stop_d  = stop_q;
        nrow_d  = nrow_q;
        npl_d   = npl_q;
        blk_d   = state_q == S_BLANK ? blk_q + BW'(1) : '0;
        case (state_q)
            S_IDLE:  if (ctrl_run && shift_rdy) state_d = S_GO;
            S_GO:    state_d = S_SWAIT;
            S_SWAIT: if (!skip_q && shift_rdy) state_d = S_DWAIT;
            S_DWAIT: if (tmr_done) state_d = S_BLANK;
            S_BLANK: if (blk_q == BW'(T_BLANK - 1)) state_d = stop_q ? S_IDLE : S_LATCH;
            S_LATCH: state_d = S_SHOW;
            S_SHOW: begin
                nrow_d  = pl_last ? nrow_q + LOG_N_ROWS'(1) : nrow_q;
                npl_d   = pl_last ? '0 : npl_q + PW'(1);
                stop_d  = last && !ctrl_run;
                state_d = stop_d ? S_DWAIT : S_GO;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) stop_d = 1'b0;
        go_d    = state_d == S_GO;
        fs_d    = go_d && nrow_d == '0 && npl_d == '0;
        srow_d  = go_d ? nrow_d : srow_q;
        spl_d   = go_d ? npl_d : spl_q;
        oh_d    = go_d ? N_PLANES'(1) << npl_d : oh_q;
        le_d    = state_d == S_LATCH;
        addr_d  = le_d ? srow_q : addr_q;
        blank_d = state_d == S_SHOW ? 1'b0 :
                  (state_d inside {S_IDLE, S_BLANK, S_LATCH}) ? 1'b1 : blank_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            nrow_q  <= '0;
            npl_q   <= '0;
            srow_q  <= '0;
            spl_q   <= '0;
            oh_q    <= N_PLANES'(1);
            addr_q  <= '0;
            blk_q   <= '0;
            go_q    <= 1'b0;
            fs_q    <= 1'b0;
            le_q    <= 1'b0;
            blank_q <= 1'b1;
            stop_q  <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nrow_q  <= nrow_d;
            npl_q   <= npl_d;
            srow_q  <= srow_d;
            spl_q   <= spl_d;
            oh_q    <= oh_d;
            addr_q  <= addr_d;
            blk_q   <= blk_d;
            go_q    <= go_d;
            fs_q    <= fs_d;
            le_q    <= le_d;
            blank_q <= blank_d;
            stop_q  <= stop_d;
            skip_q  <= state_q == S_GO;
        end
    end

    hub75_bcm_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (state_q == S_SHOW),
        .val_i  (tmr_val),
        .done_o (tmr_done)
    );

    assign frame_start = fs_q;
    assign shift_row   = srow_q;
    assign shift_plane = oh_q;
    assign shift_go    = go_q;
    assign phy_addr    = addr_q;
    assign phy_le      = le_q;
    assign phy_blank   = blank_q;
endmodule

// File: tb/tb_hub75_bcm_sched.sv
// tb_hub75_bcm_sched: scoreboard bench; stimulus queues expected shifts, latch rows and lit
// durations, a negedge monitor pops and compares them as the DUT produces events.
module tb_hub75_bcm_sched;
    localparam int NR   = 4;
    localparam int NP   = 3;
    localparam int TB   = 2;
    localparam int LR   = 2;
    localparam int SL   = 70;
    localparam int FAST = SL + 4;
    localparam int GAP  = FAST + TB + 1;

    typedef struct {int row; int pl; bit fs;} sh_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ctrl_run = 1'b1;
    logic [7:0]    cfg = 8'd100;
    logic          frame_start, shift_go, shift_rdy, phy_le, phy_blank;
    logic [LR-1:0] shift_row, phy_addr;
    logic [NP-1:0] shift_plane;

    sh_t           exp_sh[$];
    int            exp_dur[$];
    int            exp_lat[$];
    sh_t           e_m;
    int            checks = 0, errors = 0, n_go = 0, cyc = 0, low = 0;
    int            last_le = -1, gap_from = 0, busy = 0, base = 0, n0 = 0;
    bit            gap_en = 1'b0;
    logic [LR-1:0] prev_addr = '0;

    always #5 clk = ~clk;

    hub75_bcm_sched #(.N_ROWS(NR), .N_PLANES(NP), .T_BLANK(TB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl_run    (ctrl_run),
        .cfg_lsb_len (cfg),
        .frame_start (frame_start),
        .shift_row   (shift_row),
        .shift_plane (shift_plane),
        .shift_go    (shift_go),
        .shift_rdy   (shift_rdy),
        .phy_addr    (phy_addr),
        .phy_le      (phy_le),
        .phy_blank   (phy_blank)
    );

    // Shifter model: busy for SL cycles after each go.
    always @(posedge clk) begin
        if (shift_go === 1'b1) busy <= SL;
        else if (busy > 0) busy <= busy - 1;
    end
    assign shift_rdy = busy == 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_sh.delete();
            exp_dur.delete();
            exp_lat.delete();
            low = 0;
            last_le = -1;
            prev_addr = phy_addr;
        end else begin
            if (shift_go) begin
                n_go++;
                chk("go_while_busy", shift_rdy, 1);
                if (exp_sh.size() == 0) chk("go_unexpected", exp_sh.size(), 1);
                else begin
                    e_m = exp_sh.pop_front();
                    chk("go_row", shift_row, e_m.row);
                    chk("go_plane", shift_plane, 1 << e_m.pl);
                    chk("frame_start", frame_start, e_m.fs);
                    exp_lat.push_back(e_m.row);
                end
            end else if (frame_start) chk("fs_without_go", shift_go, 1);
            if (phy_le) begin
                chk("le_blank", phy_blank, 1);
                if (exp_lat.size() == 0) chk("le_unexpected", exp_lat.size(), 1);
                else chk("le_addr", phy_addr, exp_lat.pop_front());
                if (gap_en && last_le >= gap_from) chk("le_gap", cyc - last_le, GAP);
                last_le = cyc;
            end
            if (phy_addr != prev_addr) chk("addr_without_le", phy_le, 1);
            prev_addr = phy_addr;
            if (!phy_blank) low++;
            else if (low > 0) begin
                if (exp_dur.size() == 0) chk("lit_unexpected", exp_dur.size(), 1);
                else chk("lit_len", low, exp_dur.pop_front());
                low = 0;
            end
        end
    end

    task automatic wait_go(input int n, input int budget, input string what);
        int t = 0;
        while (n_go < n && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        if (n_go < n) chk(what, n_go, n);
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((exp_sh.size() + exp_dur.size() + exp_lat.size()) > 0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_pending", exp_sh.size() + exp_dur.size() + exp_lat.size(), 0);
    endtask

    initial begin
        repeat (5) begin
            @(posedge clk); #1;
            chk("rst_blank", phy_blank, 1);
            chk("rst_le", phy_le, 0);
            chk("rst_addr", phy_addr, 0);
            chk("rst_go", shift_go, 0);
        end
        // Basic scan at L=100, run dropped mid-frame.
        @(negedge clk); #1;
        for (int r = 0; r < NR; r++)
            for (int p = 0; p < NP; p++) begin
                exp_sh.push_back('{r, p, (r == 0 && p == 0)});
                exp_dur.push_back(100 << p);
            end
        rst_n = 1'b1;
        wait_go(5, 5000, "timeout_go5");
        ctrl_run = 1'b0;
        drain(6000);
        repeat (50) @(posedge clk);
        #1;
        n0 = n_go;
        repeat (200) @(posedge clk);
        #1;
        chk("idle_blank", phy_blank, 1);
        chk("idle_no_go", n_go, n0);
        // L=1: displays bounded by shift time, two frames with wrap.
        cfg = 8'd1;
        gap_from = cyc;
        gap_en = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < NR; r++)
                for (int p = 0; p < NP; p++) begin
                    exp_sh.push_back('{r, p, (r == 0 && p == 0)});
                    exp_dur.push_back((f == 1 && r == NR - 1 && p == NP - 1) ? (1 << p) : FAST);
                end
        base = n_go;
        ctrl_run = 1'b1;
        wait_go(base + NR * NP + 1, 3000, "timeout_frame2");
        ctrl_run = 1'b0;
        drain(4000);
        gap_en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        // Reset pulsed while waiting on the shifter.
        cfg = 8'd100;
        base = n_go;
        exp_sh.push_back('{0, 0, 1'b1});
        ctrl_run = 1'b1;
        wait_go(base + 1, 100, "timeout_go_pre_reset");
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_blank", phy_blank, 1);
        chk("mid_rst_le", phy_le, 0);
        chk("mid_rst_addr", phy_addr, 0);
        chk("mid_rst_go", shift_go, 0);
        chk("mid_rst_fs", frame_start, 0);
        chk("mid_rst_row", shift_row, 0);
        chk("mid_rst_plane", shift_plane, 1);
        @(negedge clk); #1;
        exp_sh.push_back('{0, 0, 1'b1});
        base = n_go;
        rst_n = 1'b1;
        wait_go(base + 1, 200, "timeout_go_post_reset");
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_shifts", exp_sh.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d errors of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
